// File: rtl/ysyx_22040365_pkg.sv
// Shared constants for the ysyx_22040365 multi-cycle core.
// Build option: YSYX_22040365_RVE_EN selects the 16-register RV64E register file.
package ysyx_22040365_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // a0 is reported as the halt code
  localparam int REG_A0 = 10;

`ifdef YSYX_22040365_RVE_EN
  localparam int NREG = 16;
`else
  localparam int NREG = 32;
`endif

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // True when a 5-bit register index exists in the configured register file
  function automatic logic reg_ok(input logic [4:0] idx);
    return (NREG == 32) || !idx[4];
  endfunction

endpackage

// File: rtl/ysyx_22040365_regfile_2r1w.sv
// Integer register file: two combinational read ports, one synchronous write
// port, synchronous clear on rst, x0 hardwired to zero.
module ysyx_22040365_regfile_2r1w #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  raddr1,
  input  logic [$clog2(NREG)-1:0]  raddr2,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [XLEN-1:0]          wdata
);

  logic [XLEN-1:0] regs [NREG];

  // Clear every register on reset, otherwise write one register; x0 writes dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/ysyx_22040365_mcore.sv
// Multi-cycle RV64I-subset core (ADDI, ADD, LUI, JAL, JALR, EBREAK).
// FETCH waits on the instruction handshake, EXEC retires one instruction,
// HALT is entered on EBREAK or on an illegal/misaligned instruction.
// Build option: YSYX_22040365_RVE_EN restricts the register file to x0..x15.
module ysyx_22040365_mcore
  import ysyx_22040365_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  output logic            commit,
  output logic [XLEN-1:0] commit_pc,
  output logic [XLEN-1:0] out,
  output logic            halt,
  output logic            halt_bad,
  output logic [XLEN-1:0] halt_code
);

  localparam int AW = $clog2(NREG);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] jalr_sum;

  logic            is_add;
  logic            wb_en;
  logic [XLEN-1:0] wb_data;
  logic            is_jump;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] pc_next;
  logic            is_ebreak;
  logic            illegal;
  logic            misaligned;
  logic            bad;
  logic            in_exec;
  logic            rf_we;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i    = XLEN'($signed(ir[31:20]));
  assign imm_u    = XLEN'($signed({ir[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  assign pc_plus4 = pc + XLEN'(4);
  assign jalr_sum = rdata1 + imm_i;

  assign is_add = (opcode == OPC_OP) && (funct3 == F3_ADD) && (funct7 == F7_ADD) &&
                  reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd);

  // Only ADD needs rs2, so the second port otherwise reads a0 for the halt code
  assign raddr2 = is_add ? rs2[AW-1:0] : AW'(REG_A0);

  assign in_exec   = (state == EXEC);
  assign inst_req  = (state == FETCH) && !rst;
  assign inst_addr = pc;

  ysyx_22040365_regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1[AW-1:0]),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (rd[AW-1:0]),
    .wdata  (wb_data)
  );

  // Decode and execute the instruction register: writeback value, next PC, faults
  always_comb begin
    wb_en       = 1'b0;
    wb_data     = '0;
    is_jump     = 1'b0;
    jump_target = '0;
    is_ebreak   = 1'b0;
    illegal     = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: begin
        if ((funct3 == F3_ADD) && reg_ok(rs1) && reg_ok(rd)) begin
          wb_en   = 1'b1;
          wb_data = rdata1 + imm_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP: begin
        if (is_add) begin
          wb_en   = 1'b1;
          wb_data = rdata1 + rdata2;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        if (reg_ok(rd)) begin
          wb_en   = 1'b1;
          wb_data = imm_u;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        if (reg_ok(rd)) begin
          wb_en       = 1'b1;
          wb_data     = pc_plus4;
          is_jump     = 1'b1;
          jump_target = pc + imm_j;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_JALR: begin
        if ((funct3 == F3_JALR) && reg_ok(rs1) && reg_ok(rd)) begin
          wb_en       = 1'b1;
          wb_data     = pc_plus4;
          is_jump     = 1'b1;
          jump_target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (ir == INST_EBREAK) begin
          is_ebreak = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign pc_next    = is_jump ? jump_target : pc_plus4;
  assign misaligned = is_jump && jump_target[1];
  assign bad        = illegal || misaligned;
  assign rf_we      = in_exec && wb_en && !bad;

  // Hold the current control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Sequence FETCH -> EXEC -> FETCH, leaving for HALT on EBREAK or a fault
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:   if (inst_valid) state_next = EXEC;
      EXEC:    state_next = (bad || is_ebreak) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // PC, instruction register and the registered retirement/halt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= XLEN'(RESET_PC);
      ir        <= '0;
      commit    <= 1'b0;
      commit_pc <= '0;
      out       <= '0;
      halt      <= 1'b0;
      halt_bad  <= 1'b0;
      halt_code <= '0;
    end else begin
      commit <= 1'b0;
      if ((state == FETCH) && inst_valid) begin
        ir <= inst;
      end
      if (in_exec) begin
        if (bad) begin
          halt      <= 1'b1;
          halt_bad  <= 1'b1;
          halt_code <= rdata2;
        end else begin
          commit    <= 1'b1;
          commit_pc <= pc;
          if (wb_en && (rd != 5'd0)) begin
            out <= wb_data;
          end
          if (is_ebreak) begin
            halt      <= 1'b1;
            halt_code <= rdata2;
          end else begin
            pc <= pc_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040365_mcore.sv
// Self-checking bench for ysyx_22040365_mcore: random and directed programs
// are fed through the fetch handshake, an ISA-level model predicts every
// retirement into a scoreboard, and a monitor checks each commit pulse.
module tb_ysyx_22040365_mcore;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
`ifdef YSYX_22040365_RVE_EN
  localparam int MNREG = 16;
`else
  localparam int MNREG = 32;
`endif

  logic            clk;
  logic            rst;
  logic            inst_req;
  logic [XLEN-1:0] inst_addr;
  logic            inst_valid;
  logic [31:0]     inst;
  logic            commit;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] out;
  logic            halt;
  logic            halt_bad;
  logic [XLEN-1:0] halt_code;

  ysyx_22040365_mcore #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst       (inst),
    .commit     (commit),
    .commit_pc  (commit_pc),
    .out        (out),
    .halt       (halt),
    .halt_bad   (halt_bad),
    .halt_code  (halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];

  // Architectural reference state
  logic [63:0] m_rf [32];
  logic [63:0] m_pc;
  logic [63:0] m_out;
  logic        m_halt;
  logic        m_bad;
  logic [63:0] m_code;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h67);
  endfunction

  function automatic logic idx_ok(input logic [4:0] i);
    return (MNREG == 32) || !i[4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc   = RESET_PC;
    m_out  = '0;
    m_halt = 1'b0;
    m_bad  = 1'b0;
    m_code = '0;
    sb.delete();
  endtask

  // Retire one instruction at the ISA level and predict the commit it produces
  task automatic model_exec(input logic [31:0] ins);
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] a, b, imm, val, target;
    logic        ok, jump;
    exp_t        e;
    opc = ins[6:0];  rd = ins[11:7];  f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a   = m_rf[rs1];
    b   = m_rf[rs2];
    imm = {{52{ins[31]}}, ins[31:20]};
    ok = 1'b1; jump = 1'b0; val = '0; target = m_pc + 64'd4;
    if (ins == 32'h0010_0073) begin
      e.pc = m_pc; e.val = m_out;
      sb.push_back(e);
      m_halt = 1'b1;
      m_code = m_rf[10];
      return;
    end
    case (opc)
      7'h13: if (f3 == 3'b000 && idx_ok(rs1) && idx_ok(rd)) val = a + imm; else ok = 1'b0;
      7'h33: if (f3 == 3'b000 && f7 == 7'b0 && idx_ok(rs1) && idx_ok(rs2) && idx_ok(rd))
               val = a + b;
             else ok = 1'b0;
      7'h37: if (idx_ok(rd)) val = {{32{ins[31]}}, ins[31:12], 12'h000}; else ok = 1'b0;
      7'h6f: begin
        ok     = idx_ok(rd);
        jump   = 1'b1;
        target = m_pc + {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        val    = m_pc + 64'd4;
      end
      7'h67: begin
        ok     = (f3 == 3'b000) && idx_ok(rs1) && idx_ok(rd);
        jump   = 1'b1;
        target = (a + imm) & ~64'd1;
        val    = m_pc + 64'd4;
      end
      default: ok = 1'b0;
    endcase
    if (jump && target[1]) ok = 1'b0;
    if (!ok) begin
      m_halt = 1'b1;
      m_bad  = 1'b1;
      m_code = m_rf[10];
      return;
    end
    e.pc = m_pc;
    if (rd != 5'd0) begin
      m_rf[rd] = val;
      m_out    = val;
    end
    e.val = m_out;
    sb.push_back(e);
    m_pc = target;
  endtask

  // Wait for a fetch request, hold it for some wait states, then hand over one word
  task automatic applyStimulus(input logic [31:0] ins, input int wait_cycles);
    int          n;
    logic [63:0] addr0;
    n = 0;
    @(negedge clk);
    while (inst_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (inst_req !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetch_timeout: got inst_req=%b, required 1", inst_req);
      return;
    end
    checkOutput("inst_addr", inst_addr, m_pc);
    addr0 = inst_addr;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      checkOutput("req_hold", {63'b0, inst_req}, 64'd1);
      checkOutput("addr_hold", inst_addr, addr0);
    end
    inst       = ins;
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    inst       = $urandom;
    model_exec(ins);
  endtask

  // Let the last instruction retire and require every predicted commit to have appeared
  task automatic settle();
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Observe the halted core while offering a stray instruction word
  task automatic check_halt();
    repeat (2) @(negedge clk);
    inst       = addi(5'd1, 5'd0, 12'd1);
    inst_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("halt_req", {63'b0, inst_req}, 64'd0);
    end
    inst_valid = 1'b0;
    checkOutput("halt", {63'b0, halt}, {63'b0, m_halt});
    checkOutput("halt_bad", {63'b0, halt_bad}, {63'b0, m_bad});
    checkOutput("halt_code", halt_code, m_code);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_inst_req", {63'b0, inst_req}, 64'd0);
    checkOutput("rst_commit", {63'b0, commit}, 64'd0);
    checkOutput("rst_commit_pc", commit_pc, 64'd0);
    checkOutput("rst_out", out, 64'd0);
    checkOutput("rst_halt", {63'b0, halt}, 64'd0);
    checkOutput("rst_halt_bad", {63'b0, halt_bad}, 64'd0);
    checkOutput("rst_halt_code", halt_code, 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: every commit pulse must match the oldest prediction
  always @(negedge clk) begin
    if (commit === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_commit: got commit_pc=0x%0h, required no commit", commit_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("commit_pc", commit_pc, e.pc);
        checkOutput("out", out, e.val);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          kind;
    int          w;
    int          off;
    logic [4:0]  rd, ra, rb;
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = '0;
    model_reset();
    do_reset();

    $display("[TB] directed arithmetic and JALR");
    applyStimulus(addi(5'd1, 5'd0, 12'd5), 0);
    applyStimulus(addi(5'd1, 5'd0, 12'hFFF), 1);
    applyStimulus(enc_add(5'd2, 5'd1, 5'd1), 0);
    applyStimulus(addi(5'd0, 5'd1, 12'd3), 2);
    applyStimulus(enc_lui(5'd1, 20'h40000), 0);
    applyStimulus(enc_add(5'd1, 5'd1, 5'd1), 0);
    applyStimulus(addi(5'd1, 5'd1, 12'h011), 0);
    applyStimulus(jalr(5'd1, 5'd1, 12'd0), 1);

    $display("[TB] random program");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      w    = $urandom_range(0, 3);
      rd   = 5'($urandom_range(0, 15));
      ra   = 5'($urandom_range(0, 15));
      rb   = 5'($urandom_range(0, 15));
      case (kind)
        0: applyStimulus(addi(rd, ra, 12'($urandom)), w);
        1: applyStimulus(enc_add(rd, ra, rb), w);
        2: applyStimulus(enc_lui(rd, 20'($urandom)), w);
        default: begin
          off = (int'($urandom_range(0, 127)) - 64) * 4;
          applyStimulus(enc_jal(rd, 21'(off)), w);
        end
      endcase
    end

    $display("[TB] LUI a0 then EBREAK");
    applyStimulus(enc_lui(5'd10, 20'h80000), 0);
    applyStimulus(32'h0010_0073, 0);
    check_halt();
    do_reset();

    $display("[TB] long fetch wait, then reset during a wait");
    applyStimulus(addi(5'd3, 5'd0, 12'd7), 7);
    settle();
    repeat (2) @(negedge clk);
    do_reset();

    $display("[TB] misaligned JALR target");
    applyStimulus(enc_lui(5'd1, 20'h40000), 0);
    applyStimulus(enc_add(5'd1, 5'd1, 5'd1), 0);
    applyStimulus(addi(5'd1, 5'd1, 12'h012), 0);
    applyStimulus(jalr(5'd1, 5'd1, 12'd0), 0);
    check_halt();
    do_reset();

    $display("[TB] illegal opcode");
    applyStimulus(addi(5'd10, 5'd0, 12'h123), 0);
    applyStimulus(32'h0000_007F, 0);
    check_halt();
    do_reset();

    $display("[TB] register index 16");
    applyStimulus(addi(5'd16, 5'd0, 12'd1), 0);
    if (m_halt) check_halt();
    else settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
